inst_fetcher: RTL

Instruction fetch stage. It sits directly upstream of the memory controller's instruction path: it drives the fetch PC and request, accepts 32-bit instructions from the controller's ICache-backed return path, and applies static branch prediction. Fetched entries go into a 4-entry queue that feeds the decoder. Fetch is redirected on ROB clear, and fetch stalls on JALR until the ROB supplies the target.

---
 rtl/inst_fetcher_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/inst_fetcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types, opcode constants and immediate decoders for the fetch stage.
package inst_fetcher_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // One fetch-queue entry as seen by the decoder.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Sign-extended J-type immediate.
    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate.
    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO with wrapping pointers, occupancy count and synchronous flush.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         i_en,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_data  = o_valid ? r_mem[r_head] : '0;

    // Pointer and count bookkeeping; flush empties the queue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop)  r_head <= r_head + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Entry storage; contents are only observed while valid.
    always_ff @(posedge clk_in) begin
        if (i_en && !i_flush && w_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage with static branch prediction and JALR stall.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [31:0] _clear_pc,
    input  logic        _stall_recover,
    input  logic [31:0] _recover_pc,
    input  logic        _inst_ready_in_Mem2Fetcher,
    input  logic [31:0] _inst_in_Mem2Fetcher,
    output logic [31:0] _pc_Fetcher2Mem,
    output logic        _InstFetcher_need_inst,
    output logic        _stall_set,
    output logic        _inst_valid_Fetcher2Decoder,
    output logic [31:0] _inst_Fetcher2Decoder,
    output logic [31:0] _pc_Fetcher2Decoder,
    output logic        _pred_taken_Fetcher2Decoder,
    output logic [31:0] _pred_pc_Fetcher2Decoder,
    input  logic        _decoder_ready
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_n;
    logic             r_stall_set;
    logic             w_stall_set_n;
    logic             w_accept;
    logic             w_pop;
    logic             w_is_jalr;
    logic             w_pred_taken;
    logic [31:0]      w_pred_pc;
    logic [CNT_W-1:0] w_count;
    logic             w_q_valid;
    logic [ENTRY_W-1:0] w_q_data;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // Static prediction of the returning instruction at the current PC.
    always_comb begin
        w_pred_taken = 1'b0;
        w_pred_pc    = r_pc + 32'd4;
        w_is_jalr    = 1'b0;
        case (_inst_in_Mem2Fetcher[6:0])
            OP_JAL: begin
                w_pred_taken = 1'b1;
                w_pred_pc    = r_pc + imm_j(_inst_in_Mem2Fetcher);
            end
            OP_BRANCH: begin
                w_pred_taken = _inst_in_Mem2Fetcher[31];
                if (_inst_in_Mem2Fetcher[31]) begin
                    w_pred_pc = r_pc + imm_b(_inst_in_Mem2Fetcher);
                end
            end
            OP_JALR: w_is_jalr = 1'b1;
            default: ;
        endcase
    end

    // Next-state: clear beats everything, returns only accepted while running.
    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_stall_set_n = 1'b0;
        w_accept      = 1'b0;
        w_pop         = w_q_valid && _decoder_ready && !_clear;
        if (_clear) begin
            w_state_n = ST_RUN;
            w_pc_n    = _clear_pc;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (_inst_ready_in_Mem2Fetcher && (w_count != CNT_W'(QDEPTH))) begin
                        w_accept = 1'b1;
                        if (w_is_jalr) begin
                            w_state_n     = ST_STALL;
                            w_stall_set_n = 1'b1;
                        end else begin
                            w_pc_n = w_pred_pc;
                        end
                    end
                end
                ST_STALL: begin
                    if (_stall_recover) begin
                        w_state_n = ST_RUN;
                        w_pc_n    = _recover_pc;
                    end
                end
                default: w_state_n = ST_RUN;
            endcase
        end
    end

    // State, PC and stall pulse registers; rdy_in low freezes them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_stall_set <= 1'b0;
        end else if (rdy_in) begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_stall_set <= w_stall_set_n;
        end
    end

    assign w_push_entry = '{inst:       _inst_in_Mem2Fetcher,
                            pc:         r_pc,
                            pred_taken: w_pred_taken,
                            pred_pc:    w_pred_pc};

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (rdy_in),
        .i_flush (_clear),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_q_data),
        .o_valid (w_q_valid),
        .o_count (w_count)
    );

    assign w_head = fetch_entry_t'(w_q_data);

    assign _pc_Fetcher2Mem             = r_pc;
    assign _InstFetcher_need_inst      = (r_state == ST_RUN) && (w_count <= CNT_W'(QDEPTH - 2));
    assign _stall_set                  = r_stall_set;
    assign _inst_valid_Fetcher2Decoder = w_q_valid;
    assign _inst_Fetcher2Decoder       = w_head.inst;
    assign _pc_Fetcher2Decoder         = w_head.pc;
    assign _pred_taken_Fetcher2Decoder = w_head.pred_taken;
    assign _pred_pc_Fetcher2Decoder    = w_head.pred_pc;

endmodule
